// File: rtl/switch_arbiter_if.sv
// Handshake bundle between one 4:1 switch output, its four upstream requesters
// and the downstream link. The slave modport is the arbiter's view.
interface switch_arbiter_if;
    logic [3:0] in_valid;
    logic [3:0] in_last;
    logic [3:0] in_ready;
    logic [3:0] sel;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;

    modport master (
        output in_valid,
        output in_last,
        output out_ready,
        input  in_ready,
        input  sel,
        input  out_valid,
        input  out_last
    );

    modport slave (
        input  in_valid,
        input  in_last,
        input  out_ready,
        output in_ready,
        output sel,
        output out_valid,
        output out_last
    );
endinterface

// File: rtl/switch_arbiter.sv
// Packet-locked arbiter for one NoC switch output: round-robin or static route,
// drives the one-hot switch select and all valid/ready handshaking.
module switch_arbiter #(
    parameter int DATA_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic             cfg_mode,
    input  logic [3:0]       cfg_src,
    output logic             cfg_err,
    switch_arbiter_if.slave  bus
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    // The data path lives in the switch; the width only guards the instantiation.
    if (DATA_WIDTH < 1) begin : g_bad_data_width
    end

    state_e     state_q, state_d;
    logic [1:0] g_q, g_d;
    logic [3:0] sel_q, sel_d;
    logic       mode_q, mode_d;
    logic [3:0] src_q, src_d;
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic       cfg_err_q, cfg_err_d;
    logic       pend_valid_q, pend_valid_d;
    logic       pend_mode_q, pend_mode_d;
    logic [3:0] pend_src_q, pend_src_d;

    logic       cfg_onehot;
    logic       cfg_ok;
    logic       dyn_found;
    logic [1:0] dyn_idx;
    logic [1:0] scan_idx;
    logic       end_of_packet;
    logic       granted;

    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        case (oh)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    always_comb begin
        cfg_onehot = (cfg_src != 4'b0000) && ((cfg_src & (cfg_src - 4'd1)) == 4'b0000);
        cfg_ok     = cfg_we && cfg_onehot;

        // Scan from the highest offset down so the nearest requester to rr_ptr wins.
        dyn_found = 1'b0;
        dyn_idx   = rr_ptr_q;
        scan_idx  = rr_ptr_q;
        for (int i = 3; i >= 0; i--) begin
            scan_idx = rr_ptr_q + 2'(i);
            if (bus.in_valid[scan_idx]) begin
                dyn_found = 1'b1;
                dyn_idx   = scan_idx;
            end
        end

        end_of_packet = (state_q == GRANT) && bus.in_valid[g_q] && bus.out_ready
                        && bus.in_last[g_q];

        state_d      = state_q;
        g_d          = g_q;
        sel_d        = sel_q;
        mode_d       = mode_q;
        src_d        = src_q;
        rr_ptr_d     = rr_ptr_q;
        cfg_err_d    = cfg_err_q || (cfg_we && !cfg_onehot);
        pend_valid_d = pend_valid_q;
        pend_mode_d  = pend_mode_q;
        pend_src_d   = pend_src_q;

        case (state_q)
            IDLE: begin
                if (cfg_ok) begin
                    mode_d = cfg_mode;
                    src_d  = cfg_src;
                end
                if (!mode_q && dyn_found) begin
                    state_d = GRANT;
                    g_d     = dyn_idx;
                    sel_d   = 4'b0001 << dyn_idx;
                end else if (mode_q && ((bus.in_valid & src_q) != 4'b0000)) begin
                    state_d = GRANT;
                    g_d     = onehot_to_idx(src_q);
                    sel_d   = src_q;
                end
            end
            GRANT: begin
                if (cfg_ok) begin
                    pend_valid_d = 1'b1;
                    pend_mode_d  = cfg_mode;
                    pend_src_d   = cfg_src;
                end
                // A write landing on the final beat is folded in on the same edge.
                if (end_of_packet) begin
                    state_d = IDLE;
                    sel_d   = 4'b0000;
                    if (!mode_q) begin
                        rr_ptr_d = g_q + 2'd1;
                    end
                    if (pend_valid_d) begin
                        mode_d = pend_mode_d;
                        src_d  = pend_src_d;
                    end
                    pend_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            g_q          <= 2'd0;
            sel_q        <= 4'b0000;
            mode_q       <= 1'b0;
            src_q        <= 4'b0001;
            rr_ptr_q     <= 2'd0;
            cfg_err_q    <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_mode_q  <= 1'b0;
            pend_src_q   <= 4'b0001;
        end else begin
            state_q      <= state_d;
            g_q          <= g_d;
            sel_q        <= sel_d;
            mode_q       <= mode_d;
            src_q        <= src_d;
            rr_ptr_q     <= rr_ptr_d;
            cfg_err_q    <= cfg_err_d;
            pend_valid_q <= pend_valid_d;
            pend_mode_q  <= pend_mode_d;
            pend_src_q   <= pend_src_d;
        end
    end

    // Handshake is masked during reset so no beat slips through the reset cycle.
    assign granted       = (state_q == GRANT) && !rst;
    assign bus.out_valid = granted && bus.in_valid[g_q];
    assign bus.out_last  = granted && bus.in_last[g_q];
    assign bus.in_ready  = (granted && bus.out_ready) ? (4'b0001 << g_q) : 4'b0000;
    assign bus.sel       = sel_q;
    assign cfg_err       = cfg_err_q;

endmodule

// File: doc/switch_arbiter.md
# switch_arbiter

Sequencing controller for one 4:1 NoC switch output. Arbitrates packets from four upstream requesters (a, b, c, d) onto a single downstream link and drives the switch's one-hot 4-bit select, so the data path itself stays in the switch. It supports dynamic round-robin arbitration and a static, configured route (Eyeriss v2-style router configuration). It sits beside each switch instance in a cluster router and owns all valid/ready handshaking for that output.

## Interface
- DATA_WIDTH, 16: width of the switch data path. It is carried for the instantiation pattern only; no data passes through this block.
- clk  in  1  clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  configuration write strobe.
- cfg_mode  in  1  0 = dynamic round-robin, 1 = static route.
- cfg_src  in  4  one-hot static source (bit0 = a … bit3 = d).
- cfg_err  out  1  sticky error: a non-one-hot cfg_src was written.
- in_valid  in  4  per-requester beat valid (bit0 = a).
- in_last  in  4  per-requester last-beat-of-packet flag.
- in_ready  out  4  per-requester beat accept.
- sel  out  4  one-hot switch select; 4'b0000 = no source.
- out_valid  out  1  downstream beat valid.
- out_last  out  1  downstream last-beat flag.
- out_ready  in  1  downstream accept.

## Operation
- **Registered config:** mode_q (reset 0), src_q (reset 4'b0001), rr_ptr (2 bits, reset 0).
- **FSM states:** IDLE, GRANT. The grant index g is registered; in GRANT, sel = onehot(g). In IDLE, sel = 0.
- **IDLE, dynamic mode:** if any in_valid bit is set, choose the first asserted requester scanning from rr_ptr upward with wrap (rr_ptr, rr_ptr+1 … mod 4). Register g and go to GRANT.
- **IDLE, static mode:** if in_valid[src_q] is set, g = index(src_q) and go to GRANT. Otherwise stay in IDLE.
- **GRANT, combinational outputs:**
  - out_valid = in_valid[g]
  - out_last = in_last[g]
  - in_ready[g] = out_ready
  - all other in_ready bits = 0
- **Beat transfer:** occurs when out_valid and out_ready are both high.
- **End of packet:** a transfer with out_last = 1 returns the FSM to IDLE. In dynamic mode it also sets rr_ptr = g+1 (mod 4). In static mode rr_ptr is unchanged.
- **Packet lock:** the grant holds for the whole packet. Other requesters' in_valid have no effect in GRANT. A requester dropping in_valid mid-packet stalls the link and does not release the grant.
- **Config write in IDLE:** cfg_we with one-hot cfg_src loads mode_q/src_q at the clock edge. The arbitration decision in that same cycle uses the old values.
- **Config write in GRANT:** the write is captured in a pending register; the latest write wins. The pending value is applied on the edge where the FSM enters IDLE, and the first IDLE cycle uses the new config.
- **Invalid config:** cfg_we with cfg_src not one-hot (including 0) is discarded in full; mode is not loaded either. cfg_err is set and stays set until rst.
- **Mode changes:** rr_ptr is not reset by a mode change.

## Timing
- **Reset (synchronous):** next edge gives state IDLE, sel = 0, in_ready = 0, out_valid = 0, out_last = 0, cfg_err = 0, pending cleared. A reset mid-packet abandons the packet; no beat is accepted in the reset cycle.
- **Arbitration latency:** in_valid rising in IDLE, cycle N, gives sel/in_ready valid in cycle N+1. Best case, the first beat transfers in N+1.
- **Throughput:** one beat per cycle within a packet while valid and ready stay high. There is exactly one IDLE bubble cycle between consecutive packets.
- **Single-beat packet:** in_last = 1 on the first beat gives GRANT for 1 cycle, then IDLE.
- **Registered outputs:** sel and the state. in_ready, out_valid and out_last are combinational from the state, in_valid/in_last and out_ready. There is no combinational path from in_valid to sel.
- **Simultaneous end of packet and pending config:** the pending config is applied and rr_ptr is updated in the same edge.

## Test plan
- **Reset defaults:** assert rst mid-packet (GRANT, g = 2) -> next cycle: sel = 0, in_ready = 0, out_valid = 0, cfg_err = 0; requester c must re-arbitrate.
- **Round-robin rotation:** all four in_valid held high, each sending 2-beat packets, out_ready = 1 -> grant order a, b, c, d, a; sel = 0001, 0010, 0100, 1000, 0001; each packet takes 2 GRANT cycles plus 1 IDLE cycle.
- **Backpressure:** b granted, 3-beat packet, out_ready toggling 1,0,1,0,1 -> exactly 3 transfers; in_ready[1] tracks out_ready; other in_ready bits stay 0; grant is held throughout.
- **Static mode:** write cfg_mode = 1, cfg_src = 4'b0100; a, b and d valid, c idle -> sel stays 0. Then c asserts -> sel = 0100 the next cycle.
- **Config during packet:** while a is granted, write cfg_mode = 1, cfg_src = 1000 -> a's packet completes unchanged; the first IDLE cycle uses static d.
- **Invalid config:** write cfg_src = 4'b0110 -> cfg_err = 1 and stays 1; mode/src unchanged; arbitration continues under the previous config.
